// File: rtl/dmem_pkg.sv
// dmem_pkg: shared op/state encodings for the stack data memory
package dmem_pkg;
  localparam int OP_W = 2;
  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;
  typedef enum logic {ST_CLEAR, ST_READY} st_e;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with registered read data
module dmem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  // one access per cycle: write, or read into the output register
  always_ff @(posedge clk)
    if (we) mem_q[addr] <= wdata;
    else rdata <= mem_q[addr];
endmodule

// File: rtl/stack_data_memory.sv
// stack_data_memory: data memory with internal stack pointer, clear sweep and valid/ready requests
module stack_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int SP_RESET       = 2**ADDR_W-1,
  parameter int STACK_LIMIT    = 2**ADDR_W-16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_empty,
  output logic              stack_full
);
  localparam logic [ADDR_W-1:0] SP_RST  = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] SP_FULL = ADDR_W'(STACK_LIMIT-1);
  st_e               st_q;
  logic [ADDR_W-1:0] clr_q, sp_q, sp_d, ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we, clearing, accept, push_ok, pop_ok, rsp_rd_q, rsp_err_q, rsp_valid_q;
  op_e               op;
  // request decode, SP next state and RAM port muxing (clear counter, req_addr, SP, SP+1)
  always_comb begin
    op        = op_e'(req_op);
    clearing  = st_q == ST_CLEAR;
    accept    = req_valid && req_ready;
    push_ok   = op == OP_PUSH && !stack_full;
    pop_ok    = op == OP_POP && !stack_empty;
    sp_d      = accept && push_ok ? sp_q - ADDR_W'(1) : accept && pop_ok ? sp_q + ADDR_W'(1) : sp_q;
    ram_we    = clearing || (accept && (op == OP_STORE || push_ok));
    ram_wdata = clearing ? '0 : req_data;
    ram_addr  = clearing ? clr_q :
                (op == OP_LOAD || op == OP_STORE) ? req_addr :
                op == OP_PUSH ? sp_q : sp_q + ADDR_W'(1);
  end
  // FSM, clear counter, stack pointer and response registers
  always_ff @(posedge clk)
    if (rst) begin
      st_q        <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      clr_q       <= '0;
      sp_q        <= SP_RST;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      st_q        <= clearing && clr_q == '1 ? ST_READY : st_q;
      clr_q       <= clearing ? clr_q + ADDR_W'(1) : clr_q;
      sp_q        <= sp_d;
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && ((op == OP_PUSH && stack_full) || (op == OP_POP && stack_empty));
      rsp_rd_q    <= accept && (op == OP_LOAD || pop_ok);
    end
  dmem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  assign req_ready   = st_q == ST_READY;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_data    = rsp_rd_q ? ram_rdata : '0;
  assign sp_out      = sp_q;
  assign stack_empty = sp_q == SP_RST;
  assign stack_full  = sp_q == SP_FULL;
endmodule
